// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous RAM between the instruction-fetch unit
// (read-only) and the load/store datapath (read/write). One transaction is
// in flight at a time: IDLE -> ISSUE -> COMPLETE for in-range accesses and
// IDLE -> COMPLETE for out-of-range accesses, which never strobe the RAM.
// Ties are broken round-robin using last_gnt (0 = fetch, 1 = data).
//
// Ports
//   clk, clear_n              clock, asynchronous active-low reset
//   f_req/f_addr              fetch request (always a read)
//   f_ack/f_rdata/f_err       fetch completion pulse, read data, range error
//   d_req/d_we/d_addr/d_wdata data request (read or write)
//   d_ack/d_rdata/d_err       data completion pulse, read data, range error
//   mem_addr/mem_read/mem_write/mem_wdata  RAM command bus
//   mem_q                     RAM read data (valid one edge after mem_read)
//   busy                      high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DEPTH = 512,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    output logic          f_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_q,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t        state_r;
    logic          last_gnt_r;
    logic          err_pending_r;
    logic          win_r;
    logic          we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          mem_read_r;
    logic          mem_write_r;
    logic          f_ack_r;
    logic          d_ack_r;
    logic          f_err_r;
    logic          d_err_r;

    logic          req_any_s;
    logic          pick_d_s;
    logic          sel_we_s;
    logic          oor_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [DW-1:0] f_rdata_s;
    logic [DW-1:0] d_rdata_s;

    // Winner selection and the command that would be latched from IDLE.
    always_comb begin
        req_any_s = f_req | d_req;
        pick_d_s  = 1'b0;
        if (f_req && d_req) begin
            pick_d_s = ~last_gnt_r;
        end else if (d_req) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
        if (pick_d_s) begin
            sel_addr_s  = d_addr;
            sel_we_s    = d_we;
            sel_wdata_s = d_wdata;
        end else begin
            // Fetch never writes; keep the previous write value on the bus.
            sel_addr_s  = f_addr;
            sel_we_s    = 1'b0;
            sel_wdata_s = mem_wdata_r;
        end
        oor_s = (sel_addr_s >= DEPTH_A);
    end

    // Transaction sequencer with registered RAM strobes and acknowledges.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r       <= S_IDLE;
            last_gnt_r    <= 1'b1;
            err_pending_r <= 1'b0;
            win_r         <= 1'b0;
            we_r          <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            f_ack_r       <= 1'b0;
            d_ack_r       <= 1'b0;
            f_err_r       <= 1'b0;
            d_err_r       <= 1'b0;
        end else begin
            // Acks and errors are single-cycle pulses unless set below.
            f_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            f_err_r <= 1'b0;
            d_err_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_any_s) begin
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        we_r        <= sel_we_s;
                        win_r       <= pick_d_s;
                        last_gnt_r  <= pick_d_s;
                        if (oor_s) begin
                            // Trap: skip the RAM entirely and report at once.
                            err_pending_r <= 1'b1;
                            state_r       <= S_COMPLETE;
                            if (pick_d_s) begin
                                d_ack_r <= 1'b1;
                                d_err_r <= 1'b1;
                            end else begin
                                f_ack_r <= 1'b1;
                                f_err_r <= 1'b1;
                            end
                        end else begin
                            err_pending_r <= 1'b0;
                            mem_write_r   <= sel_we_s;
                            mem_read_r    <= ~sel_we_s;
                            state_r       <= S_ISSUE;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    state_r     <= S_COMPLETE;
                    if (win_r) begin
                        d_ack_r <= 1'b1;
                    end else begin
                        f_ack_r <= 1'b1;
                    end
                end
                S_COMPLETE: begin
                    err_pending_r <= 1'b0;
                    state_r       <= S_IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    // Read data steering: the RAM's Q only becomes valid on the edge that
    // enters COMPLETE, so it is gated here rather than re-registered.
    always_comb begin
        f_rdata_s = '0;
        d_rdata_s = '0;
        if (f_ack_r && !we_r && !err_pending_r) begin
            f_rdata_s = mem_q;
        end else begin
            f_rdata_s = '0;
        end
        if (d_ack_r && !we_r && !err_pending_r) begin
            d_rdata_s = mem_q;
        end else begin
            d_rdata_s = '0;
        end
    end

    assign f_ack     = f_ack_r;
    assign f_err     = f_err_r;
    assign f_rdata   = f_rdata_s;
    assign d_ack     = d_ack_r;
    assign d_err     = d_err_r;
    assign d_rdata   = d_rdata_s;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign busy      = (state_r != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: self-checking bench for mem_arbiter with a 512-word
// registered RAM model, a scoreboard of expected acknowledges, and bus
// monitors counting RAM strobes.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_q;
    logic        busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .f_rdata  (f_rdata),
        .f_err    (f_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_addr (mem_addr),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_wdata(mem_wdata),
        .mem_q    (mem_q),
        .busy     (busy)
    );

    // RAM model (registered Q) plus a bench-side preload port.
    logic [31:0] ram [0:511];
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_write === 1'b1 && mem_addr < 32'd512) ram[mem_addr[8:0]] <= mem_wdata;
        if (mem_read === 1'b1 && mem_addr < 32'd512) mem_q <= ram[mem_addr[8:0]];
    end

    // Bus monitors.
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, oor_cnt = 0, dack_cnt = 0;
    always @(posedge clk) begin
        if (mem_write === 1'b1) wr_cnt <= wr_cnt + 1;
        if (mem_read === 1'b1) rd_cnt <= rd_cnt + 1;
        if (mem_read === 1'b1 && mem_write === 1'b1) both_cnt <= both_cnt + 1;
        if ((mem_read === 1'b1 || mem_write === 1'b1) && mem_addr >= 32'd512) oor_cnt <= oor_cnt + 1;
        if (d_ack === 1'b1) dack_cnt <= dack_cnt + 1;
    end

    // Bench-side memory contents (what each read should return).
    logic [31:0] exp_mem [0:511];
    logic [67:0] sb [$];
    logic [67:0] obs_now;
    assign obs_now = {f_ack, d_ack, f_err, d_err, f_rdata, d_rdata};

    function automatic logic [67:0] pack_exp(input bit port, input logic [31:0] data, input bit err);
        logic [31:0] fd;
        logic [31:0] dd;
        fd = port ? 32'h0 : data;
        dd = port ? data : 32'h0;
        return {~port, port, ~port & err, port & err, fd, dd};
    endfunction

    task automatic preload(input logic [8:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        exp_mem[a] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Waits (bounded) for any ack; counts non-busy cycles on the way.
    task automatic wait_ack(output int cyc, output int blow, output logic [67:0] obs);
        cyc = 0; blow = 0; obs = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (f_ack === 1'b1 || d_ack === 1'b1) begin
                obs = obs_now;
                break;
            end
            if (busy !== 1'b1) blow++;
        end
    endtask

    task automatic d_txn(input bit we, input logic [31:0] a, input logic [31:0] w,
                         output int cyc, output logic [67:0] obs);
        int blow;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
        wait_ack(cyc, blow, obs);
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic f_txn(input logic [31:0] a, output int cyc, output logic [67:0] obs);
        int blow;
        @(negedge clk);
        f_req = 1'b1; f_addr = a;
        wait_ack(cyc, blow, obs);
        f_req = 1'b0;
    endtask

    task automatic test_reset;
        logic [67:0] o;
        logic [67:0] e;
        int cyc;
        int w0;
        #3;
        vec_cnt++;
        if ({obs_now, mem_read, mem_write, busy, mem_addr, mem_wdata} !== 135'h0) begin
            miss_cnt++; $display("FAIL reset_vals: got %h, expected all zero", {obs_now, mem_read, mem_write, busy, mem_addr, mem_wdata});
        end
        @(negedge clk); clear_n = 1'b1;
        preload(9'h010, 32'h0BAD_F00D);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        vec_cnt++;
        if ({busy, mem_write, mem_read} !== 3'b110) begin
            miss_cnt++; $display("FAIL issue_state: got %b, expected 110", {busy, mem_write, mem_read});
        end
        w0 = wr_cnt;
        clear_n = 1'b0;
        #1;
        vec_cnt++;
        if ({obs_now, mem_read, mem_write, busy, mem_addr, mem_wdata} !== 135'h0) begin
            miss_cnt++; $display("FAIL async_reset: got %h, expected all zero", {obs_now, mem_read, mem_write, busy, mem_addr, mem_wdata});
        end
        @(negedge clk); d_req = 1'b0; d_we = 1'b0;
        @(negedge clk); clear_n = 1'b1;
        vec_cnt++;
        if (wr_cnt !== w0) begin
            miss_cnt++; $display("FAIL dropped_write: got %0d strobes, expected 0", wr_cnt - w0);
        end
        sb.push_back(pack_exp(1'b1, exp_mem[9'h010], 1'b0));
        d_txn(1'b0, 32'h10, 32'h0, cyc, o);
        e = sb.pop_front();
        vec_cnt++;
        if (o !== e || o[31:0] === 32'hDEAD_BEEF) begin
            miss_cnt++; $display("FAIL reset_readback: got %h, expected %h", o, e);
        end
    endtask

    task automatic test_write_read;
        logic [67:0] o;
        logic [67:0] e;
        int cyc;
        int w0;
        w0 = wr_cnt;
        sb.push_back(pack_exp(1'b1, 32'h0, 1'b0));
        d_txn(1'b1, 32'h87, 32'h1234_5678, cyc, o);
        exp_mem[9'h087] = 32'h1234_5678;
        e = sb.pop_front();
        vec_cnt++;
        if (o !== e) begin
            miss_cnt++; $display("FAIL wr_ack: got %h, expected %h", o, e);
        end
        vec_cnt++;
        if (cyc !== 2 || wr_cnt - w0 !== 1) begin
            miss_cnt++; $display("FAIL wr_timing: got cyc=%0d strobes=%0d, expected cyc=2 strobes=1", cyc, wr_cnt - w0);
        end
        w0 = wr_cnt;
        sb.push_back(pack_exp(1'b1, exp_mem[9'h087], 1'b0));
        d_txn(1'b0, 32'h87, 32'h0, cyc, o);
        e = sb.pop_front();
        vec_cnt++;
        if (o !== e || cyc !== 2 || wr_cnt !== w0) begin
            miss_cnt++; $display("FAIL rd_ack: got %h cyc=%0d, expected %h cyc=2", o, cyc, e);
        end
    endtask

    task automatic test_fetch;
        logic [67:0] o;
        logic [67:0] e;
        int cyc;
        int w0;
        preload(9'h000, 32'h0900_0095);
        d_we = 1'b1;
        w0 = wr_cnt;
        sb.push_back(pack_exp(1'b0, exp_mem[9'h000], 1'b0));
        f_txn(32'h0, cyc, o);
        d_we = 1'b0;
        e = sb.pop_front();
        vec_cnt++;
        if (o !== e || cyc !== 2) begin
            miss_cnt++; $display("FAIL fetch_read: got %h cyc=%0d, expected %h cyc=2", o, cyc, e);
        end
        vec_cnt++;
        if (wr_cnt !== w0) begin
            miss_cnt++; $display("FAIL fetch_no_write: got %0d strobes, expected 0", wr_cnt - w0);
        end
    endtask

    task automatic test_out_of_range;
        logic [67:0] o;
        logic [67:0] e;
        int cyc;
        int w0;
        int r0;
        w0 = wr_cnt; r0 = rd_cnt;
        sb.push_back(pack_exp(1'b1, 32'h0, 1'b1));
        d_txn(1'b1, 32'h200, 32'hFFFF_FFFF, cyc, o);
        e = sb.pop_front();
        vec_cnt++;
        if (o !== e || cyc !== 1) begin
            miss_cnt++; $display("FAIL oor_data: got %h cyc=%0d, expected %h cyc=1", o, cyc, e);
        end
        vec_cnt++;
        if (wr_cnt !== w0 || rd_cnt !== r0) begin
            miss_cnt++; $display("FAIL oor_strobe: got wr=%0d rd=%0d, expected 0 0", wr_cnt - w0, rd_cnt - r0);
        end
        sb.push_back(pack_exp(1'b0, 32'h0, 1'b1));
        f_txn(32'h8000_0000, cyc, o);
        e = sb.pop_front();
        vec_cnt++;
        if (o !== e || cyc !== 1) begin
            miss_cnt++; $display("FAIL oor_fetch: got %h cyc=%0d, expected %h cyc=1", o, cyc, e);
        end
        sb.push_back(pack_exp(1'b1, exp_mem[9'h000], 1'b0));
        d_txn(1'b0, 32'h0, 32'h0, cyc, o);
        e = sb.pop_front();
        vec_cnt++;
        if (o !== e) begin
            miss_cnt++; $display("FAIL oor_readback: got %h, expected %h", o, e);
        end
    endtask

    task automatic test_tie;
        logic [67:0] o;
        logic [67:0] e;
        int cyc;
        int blow;
        @(negedge clk); clear_n = 1'b0;
        @(negedge clk); clear_n = 1'b1;
        @(negedge clk);
        f_req = 1'b1; f_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h87;
        for (int i = 0; i < 4; i++)
            sb.push_back(pack_exp(i[0], (i[0] ? exp_mem[9'h087] : exp_mem[9'h000]), 1'b0));
        for (int i = 0; i < 4; i++) begin
            wait_ack(cyc, blow, o);
            e = sb.pop_front();
            vec_cnt++;
            if (o !== e || cyc !== (i == 0 ? 2 : 3) || blow !== (i == 0 ? 0 : 1)) begin
                miss_cnt++; $display("FAIL tie_grant%0d: got %h cyc=%0d idle=%0d, expected %h", i, o, cyc, blow, e);
            end
        end
        f_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [67:0] o;
        logic [67:0] e;
        int cyc;
        int blow;
        int d0;
        preload(9'h001, 32'hA1A1_0001);
        preload(9'h002, 32'hB2B2_0002);
        preload(9'h003, 32'hC3C3_0003);
        d0 = dack_cnt;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(pack_exp(1'b1, exp_mem[9'(i + 1)], 1'b0));
            wait_ack(cyc, blow, o);
            e = sb.pop_front();
            vec_cnt++;
            if (o !== e || cyc !== (i == 0 ? 2 : 3) || blow !== (i == 0 ? 0 : 1)) begin
                miss_cnt++; $display("FAIL hold_txn%0d: got %h cyc=%0d idle=%0d, expected %h", i, o, cyc, blow, e);
            end
            if (i < 2) d_addr = 32'(i + 2);
            else d_req = 1'b0;
        end
        repeat (5) @(negedge clk);
        vec_cnt++;
        if (dack_cnt - d0 !== 3) begin
            miss_cnt++; $display("FAIL hold_ack_count: got %0d, expected 3", dack_cnt - d0);
        end
    endtask

    initial begin
        clear_n = 1'b0; f_req = 1'b0; f_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        pre_we = 1'b0; pre_addr = 9'h0; pre_data = 32'h0;
        test_reset;
        test_write_read;
        test_fetch;
        test_out_of_range;
        test_tie;
        test_back_to_back;
        vec_cnt++;
        if (both_cnt !== 0 || oor_cnt !== 0) begin
            miss_cnt++; $display("FAIL bus_rules: got both=%0d oor=%0d, expected 0 0", both_cnt, oor_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
